// File: rtl/in_fifo_device.sv
// Buffered input peripheral: producer valid/ready into a DEPTH x 32 FIFO, drained by bridge reads, level irq.
// Optional THRESH register at addr 3 when IN_FIFO_THRESH_EN is defined; otherwise irq fires on non-empty.
module in_fifo_device #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ext_data,
    input  logic        ext_valid,
    output logic        ext_ready,
    input  logic [1:0]  addr,
    input  logic        rd_en,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_INC = AW'(1);

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [AW:0]   count_r;
    logic          irq_en_r;
    logic          irq_r;

    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic          flush_s;
    logic          irq_en_next_s;
    logic [AW:0]   count_next_s;
    logic [AW:0]   thr_s;
    logic          unused_s;

    assign empty_s   = (count_r == {(AW+1){1'b0}});
    assign full_s    = (count_r == DEPTH_C);
    assign ext_ready = !full_s;
    assign push_s    = ext_valid && !full_s;
    assign pop_s     = rd_en && (addr == 2'd0) && !empty_s;
    assign flush_s   = we && (addr == 2'd2) && wdata[1];
    assign irq       = irq_r;
    assign unused_s  = ^wdata;

`ifdef IN_FIFO_THRESH_EN
    logic [AW:0] thresh_r;
    logic [AW:0] thresh_next_s;

    // Threshold written from the bridge; zero behaves as one.
    always_comb begin
        thresh_next_s = thresh_r;
        if (we && (addr == 2'd3)) begin
            thresh_next_s = wdata[AW:0];
        end else begin
            thresh_next_s = thresh_r;
        end
        thr_s = (thresh_next_s == {(AW+1){1'b0}}) ? ONE_C : thresh_next_s;
    end

    // Threshold register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            thresh_r <= ONE_C;
        end else begin
            thresh_r <= thresh_next_s;
        end
    end
`else
    assign thr_s = ONE_C;
`endif

    // Post-update occupancy and interrupt enable; flush overrides any same-cycle push or pop.
    always_comb begin
        count_next_s  = count_r;
        irq_en_next_s = irq_en_r;
        if (flush_s) begin
            count_next_s = {(AW+1){1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + ONE_C;
                2'b01:   count_next_s = count_r - ONE_C;
                default: count_next_s = count_r;
            endcase
        end
        if (we && (addr == 2'd2)) begin
            irq_en_next_s = wdata[0];
        end else begin
            irq_en_next_s = irq_en_r;
        end
    end

    // Pointers, count, enable and the registered interrupt level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r   <= {AW{1'b0}};
            tail_r   <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            if (flush_s) begin
                head_r <= {AW{1'b0}};
                tail_r <= {AW{1'b0}};
            end else begin
                if (push_s) tail_r <= tail_r + PTR_INC;
                if (pop_s)  head_r <= head_r + PTR_INC;
            end
            count_r  <= count_next_s;
            irq_en_r <= irq_en_next_s;
            irq_r    <= irq_en_next_s && (count_next_s >= thr_s);
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_s && !flush_s) begin
            mem_r[tail_r] <= ext_data;
        end
    end

    // Register read mux.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd0: rdata = empty_s ? 32'd0 : mem_r[head_r];
            2'd1: begin
                rdata[AW:0] = count_r;
                rdata[16]   = empty_s;
                rdata[17]   = full_s;
            end
            2'd2: rdata[0] = irq_en_r;
`ifdef IN_FIFO_THRESH_EN
            2'd3: rdata[AW:0] = thresh_r;
`else
            2'd3: rdata = 32'd0;
`endif
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_in_fifo_device.sv
// Scoreboard bench for in_fifo_device: pushed words are queued and checked when read back through DATA.
module tb_in_fifo_device;

    logic        clk;
    logic        rst;
    logic [31:0] ext_data;
    logic        ext_valid;
    logic        ext_ready;
    logic [1:0]  addr;
    logic        rd_en;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb_q[$];

    in_fifo_device #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .rst(rst), .ext_data(ext_data), .ext_valid(ext_valid),
        .ext_ready(ext_ready), .addr(addr), .rd_en(rd_en), .we(we),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [31:0] d);
        ext_valid = 1'b1;
        ext_data  = d;
        #1;
        if (ext_ready) sb_q.push_back(d);
        cycle();
        ext_valid = 1'b0;
    endtask

    task automatic do_read(output logic [31:0] v, output logic [31:0] exp);
        addr  = 2'd0;
        rd_en = 1'b1;
        #1;
        v   = rdata;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'd0;
        cycle();
        rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        cycle();
        we    = 1'b0;
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b0;
        ext_valid = 1'b0; ext_data = 32'd0; addr = 2'd0; rd_en = 1'b0; we = 1'b0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        cycle();
        n_cmp++; if (ext_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b exp 1", ext_ready); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b exp 0", irq); end
        peek(2'd0, v);
        n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL reset_data got %h exp 0", v); end
        peek(2'd1, v);
        n_cmp++; if (v !== 32'h0001_0000) begin n_bad++; $display("FAIL reset_status got %h exp 00010000", v); end
        peek(2'd2, v);
        n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL reset_ctrl got %h exp 0", v); end
    endtask

    task automatic test_single();
        logic [31:0] v, e;
        do_push(32'hA5A5_0001);
        peek(2'd1, v);
        n_cmp++; if (v !== 32'h0000_0001) begin n_bad++; $display("FAIL single_status got %h exp 00000001", v); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL single_irq got %b exp 0", irq); end
        do_read(v, e);
        n_cmp++; if (v !== e) begin n_bad++; $display("FAIL single_data got %h exp %h", v, e); end
        peek(2'd1, v);
        n_cmp++; if (v !== 32'h0001_0000) begin n_bad++; $display("FAIL single_status_after got %h exp 00010000", v); end
    endtask

    task automatic test_full_wrap();
        logic [31:0] v, e;
        for (int i = 1; i <= 8; i++) do_push(32'(i));
        n_cmp++; if (ext_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b exp 0", ext_ready); end
        peek(2'd1, v);
        n_cmp++; if (v !== 32'h0002_0008) begin n_bad++; $display("FAIL full_status got %h exp 00020008", v); end
        do_push(32'd9);
        peek(2'd1, v);
        n_cmp++; if (v !== 32'h0002_0008) begin n_bad++; $display("FAIL full_hold_status got %h exp 00020008", v); end
        for (int i = 0; i < 4; i++) begin
            do_read(v, e);
            n_cmp++; if (v !== e) begin n_bad++; $display("FAIL wrap_read%0d got %h exp %h", i, v, e); end
        end
        for (int i = 9; i <= 12; i++) do_push(32'(i));
        for (int i = 0; i < 8; i++) begin
            do_read(v, e);
            n_cmp++; if (v !== e) begin n_bad++; $display("FAIL wrap_drain%0d got %h exp %h", i, v, e); end
        end
        peek(2'd1, v);
        n_cmp++; if (v !== 32'h0001_0000) begin n_bad++; $display("FAIL wrap_empty got %h exp 00010000", v); end
    endtask

    task automatic test_full_simul();
        logic [31:0] v, e;
        for (int i = 0; i < 8; i++) do_push(32'h100 + 32'(i));
        addr = 2'd0; rd_en = 1'b1; ext_valid = 1'b1; ext_data = 32'hDEAD_0099;
        #1;
        n_cmp++; if (ext_ready !== 1'b0) begin n_bad++; $display("FAIL simul_ready got %b exp 0", ext_ready); end
        v = rdata;
        e = sb_q.pop_front();
        cycle();
        rd_en = 1'b0; ext_valid = 1'b0;
        n_cmp++; if (v !== e) begin n_bad++; $display("FAIL simul_data got %h exp %h", v, e); end
        peek(2'd1, v);
        n_cmp++; if (v !== 32'h0000_0007) begin n_bad++; $display("FAIL simul_status got %h exp 00000007", v); end
        n_cmp++; if (ext_ready !== 1'b1) begin n_bad++; $display("FAIL simul_ready_after got %b exp 1", ext_ready); end
        do_push(32'hBEEF_0108);
        peek(2'd1, v);
        n_cmp++; if (v !== 32'h0002_0008) begin n_bad++; $display("FAIL simul_refill got %h exp 00020008", v); end
        for (int i = 0; i < 8; i++) begin
            do_read(v, e);
            n_cmp++; if (v !== e) begin n_bad++; $display("FAIL simul_drain%0d got %h exp %h", i, v, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v, e;
        do_push(32'h0000_CAFE);
        addr = 2'd0; rd_en = 1'b1; ext_valid = 1'b1; ext_data = 32'h0000_F00D;
        #1;
        v = rdata;
        e = sb_q.pop_front();
        sb_q.push_back(32'h0000_F00D);
        cycle();
        rd_en = 1'b0; ext_valid = 1'b0;
        n_cmp++; if (v !== e) begin n_bad++; $display("FAIL b2b_data got %h exp %h", v, e); end
        peek(2'd1, v);
        n_cmp++; if (v !== 32'h0000_0001) begin n_bad++; $display("FAIL b2b_status got %h exp 00000001", v); end
        do_read(v, e);
        n_cmp++; if (v !== e) begin n_bad++; $display("FAIL b2b_second got %h exp %h", v, e); end
    endtask

    task automatic test_irq();
        logic [31:0] v, e;
        do_write(2'd2, 32'd1);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_en_empty got %b exp 0", irq); end
        do_push(32'h1234_5678);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_rise got %b exp 1", irq); end
        do_read(v, e);
        n_cmp++; if (v !== e) begin n_bad++; $display("FAIL irq_data got %h exp %h", v, e); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_fall got %b exp 0", irq); end
        do_read(v, e);
        n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL irq_empty_read got %h exp 0", v); end
        peek(2'd1, v);
        n_cmp++; if (v !== 32'h0001_0000) begin n_bad++; $display("FAIL irq_empty_status got %h exp 00010000", v); end
        do_push(32'h0000_0042);
        do_write(2'd2, 32'd0);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_disable got %b exp 0", irq); end
        do_read(v, e);
        n_cmp++; if (v !== e) begin n_bad++; $display("FAIL irq_drain got %h exp %h", v, e); end
    endtask

    task automatic test_flush();
        logic [31:0] v, e;
        for (int i = 0; i < 5; i++) do_push(32'h500 + 32'(i));
        peek(2'd1, v);
        n_cmp++; if (v !== 32'h0000_0005) begin n_bad++; $display("FAIL flush_pre got %h exp 00000005", v); end
        ext_valid = 1'b1; ext_data = 32'h0000_0777;
        do_write(2'd2, 32'd3);
        ext_valid = 1'b0;
        sb_q.delete();
        peek(2'd1, v);
        n_cmp++; if (v !== 32'h0001_0000) begin n_bad++; $display("FAIL flush_status got %h exp 00010000", v); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL flush_irq got %b exp 0", irq); end
        peek(2'd2, v);
        n_cmp++; if (v !== 32'd1) begin n_bad++; $display("FAIL flush_ctrl got %h exp 1", v); end
        do_read(v, e);
        n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL flush_data got %h exp 0", v); end
        do_write(2'd2, 32'd0);
    endtask

`ifdef IN_FIFO_THRESH_EN
    task automatic test_thresh();
        logic [31:0] v, e;
        do_write(2'd3, 32'd4);
        do_write(2'd2, 32'd1);
        peek(2'd3, v);
        n_cmp++; if (v !== 32'd4) begin n_bad++; $display("FAIL thr_read got %h exp 4", v); end
        for (int i = 0; i < 3; i++) do_push(32'h700 + 32'(i));
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL thr_below got %b exp 0", irq); end
        do_push(32'h703);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL thr_rise got %b exp 1", irq); end
        do_read(v, e);
        n_cmp++; if (v !== e) begin n_bad++; $display("FAIL thr_data got %h exp %h", v, e); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL thr_fall got %b exp 0", irq); end
        do_write(2'd3, 32'd0);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL thr_zero got %b exp 1", irq); end
        do_write(2'd3, 32'd9);
        for (int i = 0; i < 5; i++) do_push(32'h710 + 32'(i));
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL thr_nine got %b exp 0", irq); end
        while (sb_q.size() > 0) begin
            do_read(v, e);
            n_cmp++; if (v !== e) begin n_bad++; $display("FAIL thr_drain got %h exp %h", v, e); end
        end
        do_write(2'd2, 32'd0);
        do_write(2'd3, 32'd1);
    endtask
`else
    task automatic test_no_thresh();
        logic [31:0] v;
        do_write(2'd3, 32'd5);
        peek(2'd3, v);
        n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL nothr_read got %h exp 0", v); end
        do_write(2'd1, 32'hFFFF_FFFF);
        peek(2'd1, v);
        n_cmp++; if (v !== 32'h0001_0000) begin n_bad++; $display("FAIL ro_status got %h exp 00010000", v); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] v;
        do_write(2'd2, 32'd1);
        for (int i = 0; i < 3; i++) do_push(32'h900 + 32'(i));
        #2;
        rst = 1'b0;
        #1;
        sb_q.delete();
        peek(2'd1, v);
        n_cmp++; if (v !== 32'h0001_0000) begin n_bad++; $display("FAIL rstmid_status got %h exp 00010000", v); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rstmid_irq got %b exp 0", irq); end
        cycle();
        rst = 1'b1;
        peek(2'd2, v);
        n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL rstmid_ctrl got %h exp 0", v); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_wrap();
        test_full_simul();
        test_back_to_back();
        test_irq();
        test_flush();
`ifdef IN_FIFO_THRESH_EN
        test_thresh();
`else
        test_no_thresh();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
